// File: rtl/jk_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jk_drive_ctrl
//  Description : Drives an external master-slave JK flip-flop toward a
//                requested next state, waits for it to settle, then verifies
//                the fed-back Q and counts failed checks.
//
//  Ports
//    clk        in   single clock, rising edge
//    rst        in   synchronous active-high reset
//    tgt_valid  in   a target next-state bit is offered
//    tgt_bit    in   desired Q after this step
//    tgt_ready  out  target accepted this cycle (IDLE only)
//    q_fb       in   Q fed back from the driven flip-flop
//    j, k       out  registered J/K drive
//    busy       out  high in every state except IDLE (and during reset)
//    done       out  one-cycle pulse when a step completes
//    mismatch   out  one-cycle pulse with done when the check failed
//    err_cnt    out  saturating count of failed checks
//
//  Parameters
//    SETTLE     settle cycles between drive pulse and check (1..15)
//    USE_TOGGLE 1: any change is driven as J=K=1; 0: set=10, reset=01
//    ERR_W      width of err_cnt
//
//  Revision    : 1.0  initial release
// ============================================================================
module jk_drive_ctrl #(
    parameter int SETTLE     = 2,
    parameter int USE_TOGGLE = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    localparam logic [3:0]       c_settle_cnt = 4'(SETTLE);
    localparam logic [ERR_W-1:0] c_err_max    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] c_err_one    = ERR_W'(1);

    state_t           state_q, state_d;
    logic             shadow_q, shadow_d;     // controller's belief of Q
    logic             exp_bit_q, exp_bit_d;   // Q expected at CHECK
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        exp_bit_d  = exp_bit_q;
        wait_cnt_d = wait_cnt_q;
        j_d        = 1'b0;
        k_d        = 1'b0;
        done_d     = 1'b0;
        mismatch_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_SYNC: begin
                shadow_d = q_fb;
                state_d  = ST_IDLE;
            end

            ST_IDLE: begin
                if (tgt_valid) begin
                    exp_bit_d = tgt_bit;
                    // Hold leaves J=K=0; only a change in Q gets a pulse.
                    if (tgt_bit != shadow_q) begin
                        if (USE_TOGGLE != 0) begin
                            j_d = 1'b1;
                            k_d = 1'b1;
                        end else begin
                            j_d = tgt_bit;
                            k_d = ~tgt_bit;
                        end
                    end
                    state_d = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                // J/K fall back to 00 here, so a toggle lasts one period.
                wait_cnt_d = c_settle_cnt;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                wait_cnt_d = (wait_cnt_q == 4'd0) ? 4'd0 : wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                done_d = 1'b1;
                if (q_fb != exp_bit_q) begin
                    mismatch_d = 1'b1;
                    if (err_cnt_q != c_err_max) begin
                        err_cnt_d = err_cnt_q + c_err_one;
                    end
                end
                // Resync to the real Q so the next step's excitation is right
                // even after a failed check.
                shadow_d = q_fb;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            shadow_q   <= 1'b0;
            exp_bit_q  <= 1'b0;
            wait_cnt_q <= 4'd0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            exp_bit_q  <= exp_bit_d;
            wait_cnt_q <= wait_cnt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign tgt_ready = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q != ST_IDLE) || rst;
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
